// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit and datapath:
// opcodes, FSM states, opcode classes and datapath mux encodings.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_ILLEGAL
    } cls_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_TIMEOUT = 2'd2
    } trap_cause_t;

    localparam logic [1:0] PC_PLUS4     = 2'd0;
    localparam logic [1:0] PC_ALU       = 2'd1;
    localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    function automatic cls_t decode_class(input logic [6:0] op);
        cls_t c;
        case (op)
            OP_R:      c = C_R;
            OP_I:      c = C_I;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_BRANCH: c = C_BRANCH;
            OP_JAL:    c = C_JAL;
            OP_JALR:   c = C_JALR;
            OP_LUI:    c = C_LUI;
            OP_AUIPC:  c = C_AUIPC;
            default:   c = C_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
// Used for the cycle and retired-instruction counters.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Clear wins over increment; overflow silently wraps.
    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared ready/valid memory port, with memory-timeout trap and counters.
module mc_control_fsm
    import riscv_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       ALUop,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [31:0] LIMIT = 32'(MEM_TIMEOUT);

    state_t      state;
    state_t      state_n;
    cls_t        cls;
    cls_t        cls_n;
    trap_cause_t cause;
    trap_cause_t cause_n;
    logic [31:0] wait_cnt;
    logic        timeout_hit;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;

    // Limit is checked on the registered count, so a same-cycle
    // mem_ready still completes the transfer instead of trapping.
    assign timeout_hit = (MEM_TIMEOUT > 0)
                       && (wait_cnt == LIMIT)
                       && !mem_ready;

    // State, latched opcode class and trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cls   <= C_R;
            cause <= TC_NONE;
        end else begin
            state <= state_n;
            cls   <= cls_n;
            cause <= cause_n;
        end
    end

    // Wait counter: counts stalled request cycles, clears otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt + 32'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next state and Moore outputs; everything is forced low in reset.
    always_comb begin
        state_n      = state;
        cls_n        = cls;
        cause_n      = cause;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_a_sel    = 1'b0;
        alu_b_sel    = B_RS2;
        ALUop        = ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        trap         = 1'b0;
        trap_cause   = TC_NONE;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_n = S_DECODE;
                    end else if (timeout_hit) begin
                        state_n = S_TRAP;
                        cause_n = TC_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    cls_n = decode_class(opcode);
                    if (cls_n == C_ILLEGAL) begin
                        state_n = S_TRAP;
                        cause_n = TC_ILLEGAL;
                    end else begin
                        state_n = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_n = S_WB;
                    unique case (cls)
                        C_R: begin
                            ALUop = ALU_FUNCT;
                        end
                        C_I: begin
                            alu_b_sel = B_IMM;
                            ALUop     = ALU_FUNCT;
                        end
                        C_LOAD, C_STORE: begin
                            alu_b_sel = B_IMM;
                            state_n   = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_a_sel = 1'b1;
                            alu_b_sel = B_IMM;
                            ALUop     = ALU_BR;
                            pc_we     = branch_taken;
                            pc_sel    = PC_ALU;
                            retire    = 1'b1;
                            state_n   = S_FETCH;
                        end
                        C_JAL, C_AUIPC: begin
                            alu_a_sel = 1'b1;
                            alu_b_sel = B_IMM;
                        end
                        C_JALR: begin
                            alu_b_sel = B_IMM;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls == C_STORE);
                    if (mem_ready) begin
                        if (cls == C_STORE) begin
                            retire  = 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            state_n = S_WB;
                        end
                    end else if (timeout_hit) begin
                        state_n = S_TRAP;
                        cause_n = TC_TIMEOUT;
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    state_n = S_FETCH;
                    unique case (cls)
                        C_LOAD: begin
                            wb_sel = WB_MEM;
                        end
                        C_JAL: begin
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU;
                        end
                        C_JALR: begin
                            wb_sel = WB_PC4;
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU_ALIGN;
                        end
                        C_LUI: begin
                            wb_sel = WB_IMM;
                        end
                        default: begin
                            wb_sel = WB_ALU;
                        end
                    endcase
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause;
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    perf_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .clear (reset),
        .inc   (1'b1),
        .value (cyc_q)
    );

    perf_counter #(.W(CNT_W)) u_instret (
        .clk   (clk),
        .clear (reset),
        .inc   (retire),
        .value (ins_q)
    );

    assign cycle_cnt   = reset ? '0 : cyc_q;
    assign instret_cnt = reset ? '0 : ins_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: one default instance and one with
// a 4-bit counter and MEM_TIMEOUT=4, both fed the same stimulus.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [1:0] aluop;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       br;
        logic       rdy;
        out_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'h0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;

    logic        mem_req_a, mem_we_a, mem_addr_sel_a, ir_we_a, pc_we_a;
    logic [1:0]  pc_sel_a, alu_b_sel_a, aluop_a, wb_sel_a, trap_cause_a;
    logic        alu_a_sel_a, reg_we_a, retire_a, trap_a;
    logic [31:0] cycle_cnt_a, instret_cnt_a;

    logic        mem_req_b, mem_we_b, mem_addr_sel_b, ir_we_b, pc_we_b;
    logic [1:0]  pc_sel_b, alu_b_sel_b, aluop_b, wb_sel_b, trap_cause_b;
    logic        alu_a_sel_b, reg_we_b, retire_b, trap_b;
    logic [3:0]  cycle_cnt_b, instret_cnt_b;

    out_t ga;
    out_t gb;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl[$];

    out_t Z, FH, FW, EXR, EXI, EXLS, EXBT, EXBN, EXJ, EXJR, EXAU;
    out_t MLW, MLH, MSW, MSH, WBA, WBL, WBJ, WBJR, WBU, TRI;

    localparam logic [6:0] R   = 7'h33;
    localparam logic [6:0] I   = 7'h13;
    localparam logic [6:0] LD  = 7'h03;
    localparam logic [6:0] ST  = 7'h23;
    localparam logic [6:0] BR  = 7'h63;
    localparam logic [6:0] JAL = 7'h6F;
    localparam logic [6:0] JR  = 7'h67;
    localparam logic [6:0] LUI = 7'h37;
    localparam logic [6:0] AUI = 7'h17;
    localparam logic [6:0] BAD = 7'h7F;

    always #5 clk = ~clk;

    mc_control_fsm dut_a (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req_a),
        .mem_we       (mem_we_a),
        .mem_addr_sel (mem_addr_sel_a),
        .ir_we        (ir_we_a),
        .pc_we        (pc_we_a),
        .pc_sel       (pc_sel_a),
        .alu_a_sel    (alu_a_sel_a),
        .alu_b_sel    (alu_b_sel_a),
        .ALUop        (aluop_a),
        .reg_we       (reg_we_a),
        .wb_sel       (wb_sel_a),
        .retire       (retire_a),
        .trap         (trap_a),
        .trap_cause   (trap_cause_a),
        .cycle_cnt    (cycle_cnt_a),
        .instret_cnt  (instret_cnt_a)
    );

    mc_control_fsm #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req_b),
        .mem_we       (mem_we_b),
        .mem_addr_sel (mem_addr_sel_b),
        .ir_we        (ir_we_b),
        .pc_we        (pc_we_b),
        .pc_sel       (pc_sel_b),
        .alu_a_sel    (alu_a_sel_b),
        .alu_b_sel    (alu_b_sel_b),
        .ALUop        (aluop_b),
        .reg_we       (reg_we_b),
        .wb_sel       (wb_sel_b),
        .retire       (retire_b),
        .trap         (trap_b),
        .trap_cause   (trap_cause_b),
        .cycle_cnt    (cycle_cnt_b),
        .instret_cnt  (instret_cnt_b)
    );

    assign ga = {mem_req_a, mem_we_a, mem_addr_sel_a, ir_we_a, pc_we_a,
                 pc_sel_a, alu_a_sel_a, alu_b_sel_a, aluop_a, reg_we_a,
                 wb_sel_a, retire_a, trap_a, trap_cause_a};
    assign gb = {mem_req_b, mem_we_b, mem_addr_sel_b, ir_we_b, pc_we_b,
                 pc_sel_b, alu_a_sel_b, alu_b_sel_b, aluop_b, reg_we_b,
                 wb_sel_b, retire_b, trap_b, trap_cause_b};

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [6:0] op,
                       input logic br, input logic rdy, input out_t e);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.br  = br;
        v.rdy = rdy;
        v.e   = e;
        tbl.push_back(v);
    endtask

    task automatic seq4(input logic [6:0] op, input logic br,
                        input out_t ex, input out_t fin);
        add(1'b0, op, br, 1'b1, FH);
        add(1'b0, op, br, 1'b1, Z);
        add(1'b0, op, br, 1'b1, ex);
        add(1'b0, op, br, 1'b1, fin);
    endtask

    task automatic apply(input logic rst, input logic [6:0] op,
                         input logic rdy);
        reset        = rst;
        opcode       = op;
        branch_taken = 1'b0;
        mem_ready    = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec;
        int ei;

        Z    = '0;
        FH   = '{mem_req:1'b1, ir_we:1'b1, pc_we:1'b1, default:'0};
        FW   = '{mem_req:1'b1, default:'0};
        EXR  = '{aluop:2'b10, default:'0};
        EXI  = '{alu_b_sel:2'd1, aluop:2'b10, default:'0};
        EXLS = '{alu_b_sel:2'd1, default:'0};
        EXBT = '{alu_a_sel:1'b1, alu_b_sel:2'd1, aluop:2'b01,
                 pc_we:1'b1, pc_sel:2'd1, retire:1'b1, default:'0};
        EXBN = '{alu_a_sel:1'b1, alu_b_sel:2'd1, aluop:2'b01,
                 pc_sel:2'd1, retire:1'b1, default:'0};
        EXJ  = '{alu_a_sel:1'b1, alu_b_sel:2'd1, default:'0};
        EXJR = '{alu_b_sel:2'd1, default:'0};
        EXAU = '{alu_a_sel:1'b1, alu_b_sel:2'd1, default:'0};
        MLW  = '{mem_req:1'b1, mem_addr_sel:1'b1, default:'0};
        MLH  = MLW;
        MSW  = '{mem_req:1'b1, mem_addr_sel:1'b1, mem_we:1'b1,
                 default:'0};
        MSH  = '{mem_req:1'b1, mem_addr_sel:1'b1, mem_we:1'b1,
                 retire:1'b1, default:'0};
        WBA  = '{reg_we:1'b1, retire:1'b1, default:'0};
        WBL  = '{reg_we:1'b1, retire:1'b1, wb_sel:2'd1, default:'0};
        WBJ  = '{reg_we:1'b1, retire:1'b1, wb_sel:2'd2,
                 pc_we:1'b1, pc_sel:2'd1, default:'0};
        WBJR = '{reg_we:1'b1, retire:1'b1, wb_sel:2'd2,
                 pc_we:1'b1, pc_sel:2'd2, default:'0};
        WBU  = '{reg_we:1'b1, retire:1'b1, wb_sel:2'd3, default:'0};
        TRI  = '{trap:1'b1, trap_cause:2'd1, default:'0};

        // Reset held three cycles, mem_ready already high.
        for (int k = 0; k < 3; k++) add(1'b1, R, 1'b0, 1'b1, Z);
        seq4(R, 1'b1, EXR, WBA);
        seq4(I, 1'b0, EXI, WBA);
        seq4(LUI, 1'b0, Z, WBU);
        seq4(AUI, 1'b0, EXAU, WBA);
        seq4(JAL, 1'b1, EXJ, WBJ);
        seq4(JR, 1'b0, EXJR, WBJR);
        seq4(ST, 1'b0, EXLS, MSH);
        // Zero-wait load: 5 cycles.
        add(1'b0, LD, 1'b0, 1'b1, FH);
        add(1'b0, LD, 1'b0, 1'b1, Z);
        add(1'b0, LD, 1'b0, 1'b1, EXLS);
        add(1'b0, LD, 1'b0, 1'b1, MLH);
        add(1'b0, LD, 1'b0, 1'b1, WBL);
        // Branch taken then not taken: 3 cycles each.
        add(1'b0, BR, 1'b1, 1'b1, FH);
        add(1'b0, BR, 1'b1, 1'b1, Z);
        add(1'b0, BR, 1'b1, 1'b1, EXBT);
        add(1'b0, BR, 1'b0, 1'b1, FH);
        add(1'b0, BR, 1'b0, 1'b1, Z);
        add(1'b0, BR, 1'b0, 1'b1, EXBN);
        // Load with two wait cycles in FETCH and MEM: retire in cycle 9.
        add(1'b0, LD, 1'b0, 1'b0, FW);
        add(1'b0, LD, 1'b0, 1'b0, FW);
        add(1'b0, LD, 1'b0, 1'b1, FH);
        add(1'b0, LD, 1'b0, 1'b1, Z);
        add(1'b0, LD, 1'b0, 1'b1, EXLS);
        add(1'b0, LD, 1'b0, 1'b0, MLW);
        add(1'b0, LD, 1'b0, 1'b0, MLW);
        add(1'b0, LD, 1'b0, 1'b1, MLH);
        add(1'b0, LD, 1'b0, 1'b1, WBL);
        // Store with one MEM wait.
        add(1'b0, ST, 1'b0, 1'b1, FH);
        add(1'b0, ST, 1'b0, 1'b1, Z);
        add(1'b0, ST, 1'b0, 1'b1, EXLS);
        add(1'b0, ST, 1'b0, 1'b0, MSW);
        add(1'b0, ST, 1'b0, 1'b1, MSH);
        // Reset during a pending fetch drops mem_req at once.
        add(1'b0, R, 1'b0, 1'b0, FW);
        add(1'b1, R, 1'b0, 1'b0, Z);
        // Illegal opcode, trap held 20 cycles, then reset and recover.
        add(1'b0, BAD, 1'b0, 1'b1, FH);
        add(1'b0, BAD, 1'b0, 1'b1, Z);
        for (int k = 0; k < 20; k++) add(1'b0, BAD, 1'b0, 1'b1, TRI);
        add(1'b1, R, 1'b0, 1'b1, Z);
        seq4(R, 1'b0, EXR, WBA);

        ec = 0;
        ei = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            opcode       = tbl[i].op;
            branch_taken = tbl[i].br;
            mem_ready    = tbl[i].rdy;
            @(negedge clk);
            if (tbl[i].rst) begin
                ec = 0;
                ei = 0;
            end
            chk("outs_a", i, 32'(ga), 32'(tbl[i].e));
            chk("outs_b", i, 32'(gb), 32'(tbl[i].e));
            chk("cycle_a", i, cycle_cnt_a, 32'(ec));
            chk("instret_a", i, instret_cnt_a, 32'(ei));
            chk("cycle_b", i, 32'(cycle_cnt_b), 32'(ec % 16));
            chk("instret_b", i, 32'(instret_cnt_b), 32'(ei % 16));
            if (!tbl[i].rst) begin
                ec++;
                if (tbl[i].e.retire) ei++;
            end
            next_cycle();
        end

        // Memory never ready: the timeout instance traps after 4 waits.
        apply(1'b1, R, 1'b0);
        next_cycle();
        next_cycle();
        apply(1'b0, R, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                chk("to_wait_b", c, 32'({trap_b, mem_req_b}), 32'b01);
            end else begin
                chk("to_trap_b", c,
                    32'({trap_b, trap_cause_b, mem_req_b}), 32'b1100);
            end
            chk("no_to_a", c, 32'({trap_a, mem_req_a}), 32'b01);
            next_cycle();
        end

        // mem_ready exactly on the limit cycle: no trap, normal retire.
        apply(1'b1, R, 1'b0);
        next_cycle();
        next_cycle();
        apply(1'b0, R, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) mem_ready = 1'b1;
            @(negedge clk);
            chk("lim_ir_b", c, 32'(ir_we_b), 32'(c == 5));
            chk("lim_trap_b", c, 32'(trap_b), 32'd0);
            chk("lim_ret_b", c, 32'(retire_b), 32'(c == 8));
            chk("lim_ret_a", c, 32'(retire_a), 32'(c == 8));
            next_cycle();
        end
        @(negedge clk);
        chk("lim_inst_b", 9, 32'(instret_cnt_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the next-generation RV32I core. It replaces the single-cycle decoder with a state machine that sequences FETCH/DECODE/EXEC/MEM/WB over a shared ready/valid memory port. It also adds parametrised performance counters and a memory-timeout trap. It sits beside the multi-cycle datapath and drives all of its enables and mux selects, which are one cycle per state.

## Interface
- CNT_W, 32: width of cycle and instret counters.
- MEM_TIMEOUT, 0: maximum wait cycles for mem_ready. 0 disables the timeout.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction[6:0] from the IR
- branch_taken  in  1  datapath compare result, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  latch instruction and old_pc
- pc_we  out  1  PC write enable
- pc_sel  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- alu_a_sel  out  1  0 = rs1, 1 = old_pc
- alu_b_sel  out  2  0 = rs2, 1 = imm, 2 = const 4
- ALUop  out  2  00 = add, 01 = branch compare, 10 = funct decode
- reg_we  out  1  register file write
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = old_pc+4, 3 = imm
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  core halted
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Moore outputs are decoded from the state and a latched opcode class.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. The state holds until mem_ready. On the mem_ready cycle: ir_we=1, pc_we=1, pc_sel=0. Next state is DECODE.
- DECODE: classify opcode. Legal opcodes are 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI) and 0010111 (AUIPC). Any other opcode goes to TRAP with cause 1 and does not retire.
- EXEC, by class:
  - R: a=rs1, b=rs2, ALUop=10.
  - I: a=rs1, b=imm, ALUop=10.
  - LOAD/STORE: a=rs1, b=imm, ALUop=00, then MEM.
  - BRANCH: a=old_pc, b=imm, ALUop=01. pc_we=branch_taken with pc_sel=1. retire. Next state FETCH.
  - JAL: a=old_pc, b=imm. JALR: a=rs1, b=imm. Both use ALUop=00.
  - AUIPC: a=old_pc, b=imm, ALUop=00.
  - LUI: no ALU use.
  - All classes other than BRANCH, LOAD and STORE go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. The state holds until mem_ready.
  - STORE: retire on mem_ready, next FETCH.
  - LOAD: next WB.
- WB: reg_we=1, then retire and go to FETCH.
  - wb_sel by class: R, I and AUIPC use 0; LOAD uses 1; JAL and JALR use 2; LUI uses 3.
  - JAL also asserts pc_we with pc_sel=1. JALR asserts pc_we with pc_sel=2.
- Timeout: a wait counter runs while mem_req=1 and mem_ready=0. It clears on every handshake. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT, the next state is TRAP with cause 2. mem_ready arriving in the same cycle the limit is reached wins, and no trap is taken.
- TRAP: trap=1 and all enables are 0. The state is held until reset. cycle_cnt keeps counting and instret_cnt freezes.
- Counters: cycle_cnt increments on every non-reset cycle. instret_cnt increments on retire. Both wrap modulo 2^CNT_W without flagging.

## Timing
- Reset state is FETCH. While reset is high, every output is 0, including mem_req, trap, trap_cause and both counters.
- The first mem_req appears in the first cycle after reset deasserts.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - R, I, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Handshake: mem_req, mem_we and mem_addr_sel are stable from assertion until mem_ready. A transfer occurs in the cycle where mem_req and mem_ready are both high. mem_ready while mem_req=0 is ignored.
- Reset mid-request drops mem_req in the reset cycle itself. Memory must discard the pending transaction.
- retire is high for exactly one cycle per instruction, in the final state. The instret_cnt increment is visible in the following cycle.

## Structure
- Shared package riscv_pkg contains:
  - the opcode localparams;
  - the state_t enum;
  - the pc_sel, alu_b_sel and wb_sel encodings;
  - the trap_cause_t enum.
- The datapath and the top level import the same package.
- Sub-module perf_counter #(W): clear, increment and value. It is instantiated twice, for cycle_cnt and instret_cnt.

## Test plan
- Reset held for 3 cycles, then released with mem_ready tied to 1 and an R-type instruction fed in: every output is 0 during reset. mem_req=1 appears in cycle 1 after release. retire pulses in cycle 4, with reg_we=1 and wb_sel=0 in that same cycle.
- LOAD with mem_ready delayed 2 cycles in both FETCH and MEM: retire arrives in cycle 9, and the MEM cycles show mem_req/mem_addr_sel=1 held stable. instret_cnt goes from 0 to 1.
- BRANCH with branch_taken=1, then a second BRANCH with branch_taken=0: the first has pc_we=1 and pc_sel=1 in EXEC. The second has pc_we=0 in EXEC. Each takes 3 cycles.
- JALR: WB shows reg_we=1, wb_sel=2, pc_we=1 and pc_sel=2.
- Illegal opcode 1111111: TRAP is entered after DECODE with trap=1 and trap_cause=1. There is no retire. TRAP persists for 20 cycles while cycle_cnt advances and instret_cnt holds. Reset then returns the block to FETCH.
- MEM_TIMEOUT=4 with mem_ready never asserted: trap_cause=2 appears after 4 wait cycles. A second run asserts mem_ready exactly on the limit cycle; that run gives no trap and the instruction proceeds normally.
- CNT_W=4: the counter wraps from 15 to 0 without affecting the FSM.
